udp_tx_packetizer: RTL
======================

# udp_tx_packetizer

Transmit-side framing stage that sits directly upstream of the UDP/GMII transmit core. It buffers a continuous stream of 32-bit radar samples in an internal FIFO, prepends a sequence header word to each frame, launches the UDP core with `tx_start` and fixed length fields, and serves the core's `tx_data_req` word requests. All logic runs in the Ethernet clock domain, so samples must already be synchronous to `e_rxc`.

## Interface
- `PAYLOAD_WORDS`, 256: sample words per frame; header word excluded; 1..4000.
- `FIFO_DEPTH`, 1024: sample FIFO depth in words; power of two, ≥ `PAYLOAD_WORDS`.
- `GAP_CYCLES`, 1000: idle cycles enforced after each frame before the next `tx_start`; 0 allowed.
- `MAGIC`, 16'hA55A: upper half of the header word.
- `e_rxc` in 1: single clock, the same 125 MHz clock that drives the UDP core.
- `rst_n` in 1: synchronous, active-low reset, sampled on the rising edge of `e_rxc`.
- `sample_valid` in 1: a sample is offered this cycle.
- `sample_data` in 32: sample word.
- `sample_ready` out 1: high when the FIFO is not full; combinational from the FIFO level.
- `tx_start` out 1: one-cycle pulse that starts a UDP frame.
- `tx_data_req` in 1: the UDP core requests the next payload word.
- `tx_data` out 32: payload word, registered.
- `tx_data_length` out 16: UDP length in bytes, equal to 8 + 4·(`PAYLOAD_WORDS`+1).
- `tx_total_length` out 16: IP total length, equal to `tx_data_length` + 20.
- `busy` out 1: high in every state except IDLE.
- `overflow` out 1: sticky; set when a sample is dropped.
- `req_error` out 1: sticky; set when `tx_data_req` arrives outside SEND or beyond the frame length.
- `frame_count` out 16: number of completed frames; wraps at 16'hFFFF to 0.
- `fifo_level` out log2(`FIFO_DEPTH`)+1: current FIFO occupancy.

## Operation
- **FIFO write:** on `sample_valid` && `sample_ready`, store `sample_data`. If `sample_valid` is high while the FIFO is full, drop the sample and set `overflow`; FIFO contents are unchanged.
- **Simultaneous write and read:** `fifo_level` is unchanged. A write on the cycle the level transitions away from full is accepted only if `sample_ready` was high on that cycle.
- **FSM states:** IDLE, START, SEND, GAP.
- **IDLE → START:** when `fifo_level` ≥ `PAYLOAD_WORDS`.
- **START:** assert `tx_start` for exactly one cycle, load the word counter with 0, then go to SEND.
- **SEND:** each sampled `tx_data_req` with word counter = 0 loads `tx_data` = {`MAGIC`, `seq`}. A request with counter 1..`PAYLOAD_WORDS` pops the FIFO head into `tx_data`. The counter increments on each accepted request. After the request with counter = `PAYLOAD_WORDS`: increment `seq` and `frame_count`, load the gap counter, and go to GAP.
- **GAP:** decrement the gap counter each cycle; go to IDLE at 0. With `GAP_CYCLES` = 0, GAP lasts one cycle.
- **Stray requests:** `tx_data_req` in IDLE, START or GAP sets `req_error`. `tx_data` is driven to 0 and no FIFO pop occurs.
- **`seq`:** internal 16-bit counter, reset to 0, wraps at 16'hFFFF to 0. The first frame after reset carries `seq` = 0.
- **Length outputs:** constants computed from parameters at elaboration, driven from registers that load at reset. They are stable in all states.
- **Drop policy:** sample ingest continues during SEND and GAP. There is no backpressure beyond `sample_ready`.

## Timing
- **Reset values:** `tx_start` 0, `tx_data` 0, `busy` 0, `overflow` 0, `req_error` 0, `frame_count` 0, `fifo_level` 0, `sample_ready` 1. The FSM is in IDLE and `seq` is 0. The length outputs hold their constants.
- **Reset mid-frame:** flush the FIFO and clear all state on the next edge. No further `tx_start` until the FIFO refills to `PAYLOAD_WORDS`.
- **Start latency:** `tx_start` rises 2 cycles after the write that makes `fifo_level` reach `PAYLOAD_WORDS`. Cycle 1 updates the level; cycle 2 is START.
- **Data latency:** if `tx_data_req` is high in cycle n, `tx_data` holds the corresponding word from cycle n+1 until the next accepted request. Back-to-back requests every cycle are supported at full rate.
- **Minimum frame spacing:** from one `tx_start` to the next is 1 + (`PAYLOAD_WORDS`+1 request cycles) + max(`GAP_CYCLES`,1) + 1 cycles.
- **`frame_count` update:** increments on the edge after the final request.

## Test plan
- **Single frame:** `PAYLOAD_WORDS`=4, `GAP_CYCLES`=2; write samples 1..4, then issue 5 consecutive requests. Required: one `tx_start` pulse; `tx_data` sequence A55A0000, 1, 2, 3, 4; `tx_data_length`=28, `tx_total_length`=48; `frame_count`=1.
- **Back-to-back frames:** write samples 1..8, then serve two frames. Required: second header A55A0001 with payload 5..8, and at least 2 idle cycles between the end of frame 1 and the second `tx_start`.
- **Overflow:** `FIFO_DEPTH`=8; hold `sample_valid` high for 10 cycles with no requests. Required: `sample_ready` low after 8 writes, `overflow`=1, and the FIFO holds samples 1..8.
- **Stray and extra requests:** pulse `tx_data_req` in IDLE, then issue a 6th request at the end of a 4-word frame. Required: `req_error`=1, `tx_data`=0 for both stray requests, and `fifo_level` unchanged by them.
- **Reset mid-SEND:** drive `rst_n` low after the 2nd request. Required: all outputs return to their reset values on the next edge, and no `tx_start` occurs until 4 new samples have been written.
- **Sequence wrap:** preload through 65536 frames (or force `seq`=16'hFFFF). Required: headers A55AFFFF then A55A0000; `frame_count` wraps to 0.

Source files
------------

// File: rtl/udp_tx_packetizer.sv
// udp_tx_packetizer
// Framing stage ahead of the UDP/GMII transmit core. Samples are buffered in a FIFO. Each
// frame is a header word {MAGIC, seq} followed by PAYLOAD_WORDS samples, delivered one word
// per tx_data_req.
//
// Ports (all synchronous to e_rxc):
//   e_rxc, rst_n             clock, synchronous active-low reset
//   sample_valid/data/ready  sample ingest; ready is high while the FIFO is not full
//   tx_start                 one-cycle pulse that launches a UDP frame
//   tx_data_req, tx_data     word request from the core, registered word back
//   tx_data_length           UDP length in bytes (constant)
//   tx_total_length          IP total length in bytes (constant)
//   busy                     FSM is not idle
//   overflow, req_error      sticky error flags
//   frame_count              completed frames, wraps
//   fifo_level               current FIFO occupancy
module udp_tx_packetizer #(
  parameter int unsigned PAYLOAD_WORDS = 256,
  parameter int unsigned FIFO_DEPTH    = 1024,
  parameter int unsigned GAP_CYCLES    = 1000,
  parameter logic [15:0] MAGIC         = 16'hA55A
) (
  input  logic                         e_rxc,
  input  logic                         rst_n,
  input  logic                         sample_valid,
  input  logic [31:0]                  sample_data,
  output logic                         sample_ready,
  output logic                         tx_start,
  input  logic                         tx_data_req,
  output logic [31:0]                  tx_data,
  output logic [15:0]                  tx_data_length,
  output logic [15:0]                  tx_total_length,
  output logic                         busy,
  output logic                         overflow,
  output logic                         req_error,
  output logic [15:0]                  frame_count,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] FRAME_LVL = LW'(PAYLOAD_WORDS);
  localparam logic [15:0]   LAST_WORD = 16'(PAYLOAD_WORDS);
  localparam logic [15:0]   DATA_LEN  = 16'(8 + 4 * (PAYLOAD_WORDS + 1));
  localparam logic [15:0]   TOTAL_LEN = DATA_LEN + 16'd20;
  // GAP always lasts at least one cycle, so a zero gap loads the same value as a gap of one.
  localparam logic [31:0]   GAP_LOAD  = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StStart, StSend, StGap} state_e;

  state_e          state_q, state_d;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [15:0]     word_cnt_q, word_cnt_d;
  logic [31:0]     gap_cnt_q, gap_cnt_d;
  logic [15:0]     seq_q, seq_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic [31:0]     tx_data_q, tx_data_d;
  logic            overflow_q, req_error_q, req_error_d;
  logic [15:0]     data_len_q, total_len_q;
  logic            wr_en, rd_en;

  assign sample_ready    = (level_q != FULL_LVL);
  assign wr_en           = sample_valid && sample_ready;
  assign fifo_level      = level_q;
  assign tx_data         = tx_data_q;
  assign busy            = (state_q != StIdle);
  assign overflow        = overflow_q;
  assign req_error       = req_error_q;
  assign frame_count     = frame_count_q;
  assign tx_data_length  = data_len_q;
  assign tx_total_length = total_len_q;

  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    seq_d         = seq_q;
    frame_count_d = frame_count_q;
    tx_data_d     = tx_data_q;
    req_error_d   = req_error_q;
    rd_en         = 1'b0;
    tx_start      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tx_data_req) begin
          req_error_d = 1'b1;
          tx_data_d   = '0;
        end
        if (level_q >= FRAME_LVL) state_d = StStart;
      end
      StStart: begin
        tx_start   = 1'b1;
        word_cnt_d = '0;
        if (tx_data_req) begin
          req_error_d = 1'b1;
          tx_data_d   = '0;
        end
        state_d = StSend;
      end
      StSend: begin
        if (tx_data_req) begin
          if (word_cnt_q == 16'd0) begin
            tx_data_d = {MAGIC, seq_q};
          end else begin
            // Level was >= PAYLOAD_WORDS at START and only this frame pops, so never empty.
            rd_en     = 1'b1;
            tx_data_d = mem[rd_ptr_q];
          end
          word_cnt_d = word_cnt_q + 16'd1;
          if (word_cnt_q == LAST_WORD) begin
            seq_d         = seq_q + 16'd1;
            frame_count_d = frame_count_q + 16'd1;
            gap_cnt_d     = GAP_LOAD;
            state_d       = StGap;
          end
        end
      end
      StGap: begin
        // Covers requests past the end of the frame as well as late strays.
        if (tx_data_req) begin
          req_error_d = 1'b1;
          tx_data_d   = '0;
        end
        if (gap_cnt_q == 32'd0) state_d = StIdle;
        else                    gap_cnt_d = gap_cnt_q - 32'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage is not reset; pointer reset is enough to flush it.
  always_ff @(posedge e_rxc) begin
    if (wr_en) mem[wr_ptr_q] <= sample_data;
  end

  always_ff @(posedge e_rxc) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      word_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      seq_q         <= '0;
      frame_count_q <= '0;
      tx_data_q     <= '0;
      overflow_q    <= 1'b0;
      req_error_q   <= 1'b0;
      data_len_q    <= DATA_LEN;
      total_len_q   <= TOTAL_LEN;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      word_cnt_q    <= word_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      seq_q         <= seq_d;
      frame_count_q <= frame_count_d;
      tx_data_q     <= tx_data_d;
      req_error_q   <= req_error_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (sample_valid && !sample_ready) overflow_q <= 1'b1;
    end
  end

endmodule
